// File: rtl/pe_pkg.sv
// Shared types for the lane-wise processing elements.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
// Contents: pe_op_e, the runtime operation selector carried on MODE.
package pe_pkg;

  typedef enum logic [1:0] {
    PE_ADD = 2'd0,  // D1 + D2, modulo 2^W per lane
    PE_SUB = 2'd1,  // D1 - D2, modulo 2^W per lane
    PE_MAX = 2'd2,  // signed maximum, D1 on tie
    PE_MIN = 2'd3   // signed minimum, D1 on tie
  } pe_op_e;

endpackage

// File: rtl/pe_fifo_sync.sv
// Synchronous first-word-fall-through FIFO, DEPTH x WIDTH, with registered occupancy.
// Latency: a beat pushed at edge t is at dout during cycle t+1.
// Backpressure: prog_full when occupancy >= THRESH; a push into a full FIFO without a pop is dropped and pulses overrun.
// Ports: CLK, RST (async, active-high); push/din write side; pop/dout read side;
//        ne (not empty), full, prog_full, overrun (one-cycle pulse per dropped beat).
module pe_fifo_sync #(
  parameter int WIDTH  = 512,
  parameter int DEPTH  = 512,
  parameter int THRESH = 400
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             ne,
  output logic             full,
  output logic             prog_full,
  output logic             overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC   = (AW+1)'(DEPTH);
  localparam logic [AW:0] THRESH_OCC = (AW+1)'(THRESH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      occ;
  logic             do_push;
  logic             do_pop;

  assign ne        = (occ != '0);
  assign full      = (occ == FULL_OCC);
  assign prog_full = (occ >= THRESH_OCC);

  // A pop in the same cycle frees the head slot, so a push into a full
  // FIFO is still accepted when it coincides with a pop.
  assign do_pop  = pop & ne;
  assign do_push = push & (~full | do_pop);
  assign overrun = push & full & ~do_pop;

  assign dout = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/pe_binop.sv
// Two-operand lane-wise PE: joins two FIFO-buffered streams and applies ADD/SUB/MAX/MIN per lane.
// Latency: 2 edges from the later of the two pushes to Q_VALID; 1 beat/cycle sustained.
// Backpressure: Q_BP freezes Q/Q_VALID and stops pops; D1_BP/D2_BP flag FIFO occupancy >= BP_THRESH.
// Ports: CLK, RST (async, active-high); D1/D2 + D1_VALID/D2_VALID operand streams; D1_BP/D2_BP;
//        MODE (sampled at pop); Q_BP; Q/Q_VALID result; OVR sticky overrun flags; CNT result count; CLR.
module pe_binop
  import pe_pkg::*;
#(
  parameter int LANES     = 8,
  parameter int W         = 64,
  parameter int DEPTH     = 512,
  parameter int BP_THRESH = 400,
  parameter int CNT_W     = 32
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [LANES-1:0][W-1:0]   D1,
  input  logic                      D1_VALID,
  output logic                      D1_BP,
  input  logic [LANES-1:0][W-1:0]   D2,
  input  logic                      D2_VALID,
  output logic                      D2_BP,
  input  logic [1:0]                MODE,
  input  logic                      Q_BP,
  output logic [LANES-1:0][W-1:0]   Q,
  output logic                      Q_VALID,
  output logic [1:0]                OVR,
  output logic [CNT_W-1:0]          CNT,
  input  logic                      CLR
);

  typedef logic [W-1:0] lane_t;

  logic [LANES-1:0][W-1:0] head1;
  logic [LANES-1:0][W-1:0] head2;
  logic [LANES-1:0][W-1:0] res;
  logic                    ne1, ne2;
  logic                    unused_full1, unused_full2;
  logic                    ovr1, ovr2;
  logic                    pop;
  pe_op_e                  op;

  pe_fifo_sync #(.WIDTH(LANES*W), .DEPTH(DEPTH), .THRESH(BP_THRESH)) u_fifo1 (
    .CLK       (CLK),
    .RST       (RST),
    .push      (D1_VALID),
    .din       (D1),
    .pop       (pop),
    .dout      (head1),
    .ne        (ne1),
    .full      (unused_full1),
    .prog_full (D1_BP),
    .overrun   (ovr1)
  );

  pe_fifo_sync #(.WIDTH(LANES*W), .DEPTH(DEPTH), .THRESH(BP_THRESH)) u_fifo2 (
    .CLK       (CLK),
    .RST       (RST),
    .push      (D2_VALID),
    .din       (D2),
    .pop       (pop),
    .dout      (head2),
    .ne        (ne2),
    .full      (unused_full2),
    .prog_full (D2_BP),
    .overrun   (ovr2)
  );

  // Both heads leave together, and only when the result register may advance.
  assign pop = ne1 & ne2 & ~Q_BP;
  assign op  = pe_op_e'(MODE);

  // Ties in MAX/MIN resolve to the D1 operand.
  function automatic lane_t lane_op(input pe_op_e o, input lane_t a, input lane_t b);
    case (o)
      PE_ADD:  lane_op = a + b;
      PE_SUB:  lane_op = a - b;
      PE_MAX:  lane_op = ($signed(a) >= $signed(b)) ? a : b;
      default: lane_op = ($signed(a) <= $signed(b)) ? a : b;
    endcase
  endfunction

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign res[g] = lane_op(op, head1[g], head2[g]);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Q       <= '0;
      Q_VALID <= 1'b0;
      CNT     <= '0;
      OVR     <= 2'b00;
    end else begin
      if (pop) begin
        Q       <= res;
        Q_VALID <= 1'b1;
      end else if (!Q_BP) begin
        Q_VALID <= 1'b0;
      end

      // A clear coinciding with a pop still counts that pop.
      if (CLR)      CNT <= pop ? CNT_W'(1) : '0;
      else if (pop) CNT <= CNT + CNT_W'(1);

      // A new overrun wins over a simultaneous clear.
      OVR <= (CLR ? 2'b00 : OVR) | {ovr2, ovr1};
    end
  end

endmodule
